// File: rtl/clock_pkg.sv
// Shared types and constants for the time-setting controller and its helpers.
package clock_pkg;

    localparam int HOUR_W       = 5;
    localparam int MS_W         = 6;
    localparam int HOUR_MAX_DEF = 23;
    localparam int MS_MAX_DEF   = 59;
    localparam int TIMEOUT_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        SET_HOUR,
        SET_MIN,
        SET_SEC,
        COMMIT
    } set_state_t;

    typedef enum logic [1:0] {
        F_NONE,
        F_HOUR,
        F_MIN,
        F_SEC
    } edit_field_t;

    // Maps an editor state onto the field indicator shown to the display.
    function automatic edit_field_t field_of(input set_state_t s);
        case (s)
            SET_HOUR: return F_HOUR;
            SET_MIN:  return F_MIN;
            SET_SEC:  return F_SEC;
            default:  return F_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wrap_step.sv
// One-step up/down adjuster for a time field, wrapping between 0 and MAX.
module wrap_step #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] i_value,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_next
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Inc and dec together cancel out; an out-of-range value is pulled back into 0..MAX.
    always_comb begin
        o_next = i_value;
        if (i_inc && !i_dec) begin
            o_next = (i_value >= MAX_V) ? '0 : i_value + W'(1);
        end else if (i_dec && !i_inc) begin
            o_next = ((i_value == '0) || (i_value > MAX_V)) ? MAX_V : i_value - W'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: freezes the clock counter while the user edits
// hour/minute/second, then issues one atomic load of the edited time.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10,
    parameter int HOUR_MAX    = HOUR_MAX_DEF,
    parameter int MS_MAX      = MS_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_sec_tick,
    input  logic [HOUR_W-1:0] i_cur_hour,
    input  logic [MS_W-1:0]   i_cur_minute,
    input  logic [MS_W-1:0]   i_cur_second,
    input  logic              i_btn_mode,
    input  logic              i_btn_inc,
    input  logic              i_btn_dec,
    input  logic              i_btn_cancel,
    output logic              o_pause,
    output logic              o_load,
    output logic [HOUR_W-1:0] o_load_hour,
    output logic [MS_W-1:0]   o_load_minute,
    output logic [MS_W-1:0]   o_load_second,
    output logic [1:0]        o_edit_field,
    output logic              o_blink,
    output logic              o_busy
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_SEC - 1);

    set_state_t           r_state;
    set_state_t           w_next_state;

    logic [HOUR_W-1:0]    r_hour;
    logic [MS_W-1:0]      r_minute;
    logic [MS_W-1:0]      r_second;
    logic [TIMEOUT_W-1:0] r_timeout;

    logic                 r_pause;
    logic                 r_load;
    logic                 r_blink;
    logic                 r_busy;
    edit_field_t          r_field;

    logic                 w_pause_d;
    logic                 w_load_d;
    logic                 w_blink_d;
    logic                 w_busy_d;
    edit_field_t          w_field_d;
    logic [TIMEOUT_W-1:0] w_timeout_d;

    logic                 w_in_set;
    logic                 w_next_in_set;
    logic                 w_any_btn;
    logic                 w_timeout_hit;
    logic                 w_abort;
    logic                 w_edit_en;

    logic [HOUR_W-1:0]    w_hour_step;
    logic [MS_W-1:0]      w_minute_step;
    logic [MS_W-1:0]      w_second_step;

    assign w_in_set      = (r_state == SET_HOUR) || (r_state == SET_MIN) || (r_state == SET_SEC);
    assign w_next_in_set = (w_next_state == SET_HOUR) || (w_next_state == SET_MIN) ||
                           (w_next_state == SET_SEC);
    assign w_any_btn     = i_btn_mode || i_btn_inc || i_btn_dec || i_btn_cancel;

    // A button on the same edge as the final tick keeps the edit alive.
    assign w_timeout_hit = w_in_set && i_sec_tick && !w_any_btn && (r_timeout == TIMEOUT_LAST);
    assign w_abort       = w_in_set && (i_btn_cancel || w_timeout_hit);

    // Field edits only happen when neither cancel nor mode claims the cycle.
    assign w_edit_en     = w_in_set && !i_btn_cancel && !i_btn_mode;

    wrap_step #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour_step (
        .i_value (r_hour),
        .i_inc   (w_edit_en && (r_state == SET_HOUR) && i_btn_inc),
        .i_dec   (w_edit_en && (r_state == SET_HOUR) && i_btn_dec),
        .o_next  (w_hour_step)
    );

    wrap_step #(.W(MS_W), .MAX(MS_MAX)) u_minute_step (
        .i_value (r_minute),
        .i_inc   (w_edit_en && (r_state == SET_MIN) && i_btn_inc),
        .i_dec   (w_edit_en && (r_state == SET_MIN) && i_btn_dec),
        .o_next  (w_minute_step)
    );

    wrap_step #(.W(MS_W), .MAX(MS_MAX)) u_second_step (
        .i_value (r_second),
        .i_inc   (w_edit_en && (r_state == SET_SEC) && i_btn_inc),
        .i_dec   (w_edit_en && (r_state == SET_SEC) && i_btn_dec),
        .o_next  (w_second_step)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: cancel/timeout beats mode, commit always returns to idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_btn_mode) w_next_state = SET_HOUR;
            end
            SET_HOUR: begin
                if (w_abort)         w_next_state = IDLE;
                else if (i_btn_mode) w_next_state = SET_MIN;
            end
            SET_MIN: begin
                if (w_abort)         w_next_state = IDLE;
                else if (i_btn_mode) w_next_state = SET_SEC;
            end
            SET_SEC: begin
                if (w_abort)         w_next_state = IDLE;
                else if (i_btn_mode) w_next_state = COMMIT;
            end
            COMMIT:   w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output comes straight from a flop.
    always_comb begin
        w_pause_d = (w_next_state != IDLE);
        w_busy_d  = (w_next_state != IDLE);
        w_load_d  = (w_next_state == COMMIT);
        w_field_d = field_of(w_next_state);

        w_blink_d = 1'b0;
        if (w_next_in_set) begin
            w_blink_d = w_in_set ? (r_blink ^ i_sec_tick) : 1'b1;
        end

        w_timeout_d = '0;
        if (w_in_set && w_next_in_set && !w_any_btn) begin
            w_timeout_d = i_sec_tick ? (r_timeout + TIMEOUT_W'(1)) : r_timeout;
        end
    end

    // Registered outputs and the inactivity counter.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_pause   <= 1'b0;
            r_load    <= 1'b0;
            r_blink   <= 1'b0;
            r_busy    <= 1'b0;
            r_field   <= F_NONE;
            r_timeout <= '0;
        end else begin
            r_pause   <= w_pause_d;
            r_load    <= w_load_d;
            r_blink   <= w_blink_d;
            r_busy    <= w_busy_d;
            r_field   <= w_field_d;
            r_timeout <= w_timeout_d;
        end
    end

    // Shadow time: snapshot the live counter on entry, then apply field edits.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_hour   <= '0;
            r_minute <= '0;
            r_second <= '0;
        end else if ((r_state == IDLE) && i_btn_mode) begin
            r_hour   <= i_cur_hour;
            r_minute <= i_cur_minute;
            r_second <= i_cur_second;
        end else if (w_edit_en) begin
            r_hour   <= w_hour_step;
            r_minute <= w_minute_step;
            r_second <= w_second_step;
        end
    end

    assign o_pause       = r_pause;
    assign o_load        = r_load;
    assign o_blink       = r_blink;
    assign o_busy        = r_busy;
    assign o_edit_field  = r_field;
    assign o_load_hour   = r_hour;
    assign o_load_minute = r_minute;
    assign o_load_second = r_second;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed table, timeout sequences,
// then random stimulus against a behavioural model of the editor.
module tb_clock_set_ctrl;

    localparam int TO    = 3;
    localparam int HMAX  = 23;
    localparam int MSMAX = 59;

    logic       clk;
    logic       rstn;
    logic       secTick;
    logic [4:0] curHour;
    logic [5:0] curMinute;
    logic [5:0] curSecond;
    logic       btnMode;
    logic       btnInc;
    logic       btnDec;
    logic       btnCancel;
    logic       pause;
    logic       load;
    logic [4:0] loadHour;
    logic [5:0] loadMinute;
    logic [5:0] loadSecond;
    logic [1:0] editField;
    logic       blink;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Model: mFld 0 = idle, 1..3 = editing hour/min/sec, 4 = commit cycle.
    int mFld  = 0;
    int mH    = 0;
    int mM    = 0;
    int mS    = 0;
    int mIdle = 0;
    int mBlink = 0;

    clock_set_ctrl #(.TIMEOUT_SEC(TO)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_sec_tick    (secTick),
        .i_cur_hour    (curHour),
        .i_cur_minute  (curMinute),
        .i_cur_second  (curSecond),
        .i_btn_mode    (btnMode),
        .i_btn_inc     (btnInc),
        .i_btn_dec     (btnDec),
        .i_btn_cancel  (btnCancel),
        .o_pause       (pause),
        .o_load        (load),
        .o_load_hour   (loadHour),
        .o_load_minute (loadMinute),
        .o_load_second (loadSecond),
        .o_edit_field  (editField),
        .o_blink       (blink),
        .o_busy        (busy)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit mode;
        bit inc;
        bit dec;
        bit cancel;
        int ch;
        int cm;
        int cs;
        int ePause;
        int eLoad;
        int eField;
        int eH;
        int eM;
        int eS;
    } vec_t;

    vec_t tbl[20];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        int eField;
        eField = (mFld >= 1 && mFld <= 3) ? mFld : 0;
        cmp({name, ".pause"}, 32'(pause), 32'(mFld != 0));
        cmp({name, ".busy"},  32'(busy),  32'(mFld != 0));
        cmp({name, ".load"},  32'(load),  32'(mFld == 4));
        cmp({name, ".field"}, 32'(editField), eField);
        cmp({name, ".blink"}, 32'(blink), mBlink);
        cmp({name, ".hour"},  32'(loadHour),   mH);
        cmp({name, ".min"},   32'(loadMinute), mM);
        cmp({name, ".sec"},   32'(loadSecond), mS);
    endtask

    // Adjusts the selected field of the model with modular arithmetic.
    task automatic modelAdjust(input int dir);
        case (mFld)
            1: mH = (mH + HMAX + 1 + dir) % (HMAX + 1);
            2: mM = (mM + MSMAX + 1 + dir) % (MSMAX + 1);
            3: mS = (mS + MSMAX + 1 + dir) % (MSMAX + 1);
            default: ;
        endcase
    endtask

    // Drives one cycle of inputs, advances the model, then checks after the edge.
    task automatic applyStimulus(input bit rn, input bit mode, input bit inc, input bit dec,
                                 input bit cancel, input bit tick,
                                 input int ch, input int cm, input int cs, input string name);
        rstn      = rn;
        btnMode   = mode;
        btnInc    = inc;
        btnDec    = dec;
        btnCancel = cancel;
        secTick   = tick;
        curHour   = 5'(ch);
        curMinute = 6'(cm);
        curSecond = 6'(cs);

        if (!rn) begin
            mFld = 0; mH = 0; mM = 0; mS = 0; mIdle = 0; mBlink = 0;
        end else if (mFld == 0) begin
            if (mode) begin
                mFld = 1; mH = ch; mM = cm; mS = cs; mIdle = 0; mBlink = 1;
            end
        end else if (mFld == 4) begin
            mFld = 0; mBlink = 0; mIdle = 0;
        end else if (cancel) begin
            mFld = 0; mBlink = 0; mIdle = 0;
        end else if (mode) begin
            mFld = mFld + 1;
            mIdle = 0;
            mBlink = (mFld == 4) ? 0 : (mBlink ^ int'(tick));
        end else if (inc || dec) begin
            if (inc && !dec) modelAdjust(1);
            if (dec && !inc) modelAdjust(-1);
            mIdle = 0;
            mBlink = mBlink ^ int'(tick);
        end else if (tick) begin
            mIdle = mIdle + 1;
            if (mIdle == TO) begin
                mFld = 0; mBlink = 0; mIdle = 0;
            end else begin
                mBlink = mBlink ^ 1;
            end
        end

        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    initial begin
        vec_t v;

        rstn = 1'b0; secTick = 1'b0; btnMode = 1'b0; btnInc = 1'b0;
        btnDec = 1'b0; btnCancel = 1'b0;
        curHour = 5'd12; curMinute = 6'd34; curSecond = 6'd56;

        //           mode inc dec can  ch  cm  cs  P  L  F  H   M   S
        tbl[0]  = '{0, 0, 0, 0, 12, 34, 56, 0, 0, 0, 0,  0,  0};
        tbl[1]  = '{1, 0, 0, 0, 12, 34, 56, 1, 0, 1, 12, 34, 56};
        tbl[2]  = '{0, 0, 0, 1, 12, 34, 56, 0, 0, 0, 12, 34, 56};
        tbl[3]  = '{1, 0, 0, 0, 23, 0,  30, 1, 0, 1, 23, 0,  30};
        tbl[4]  = '{0, 1, 0, 0, 23, 0,  30, 1, 0, 1, 0,  0,  30};
        tbl[5]  = '{0, 0, 1, 0, 23, 0,  30, 1, 0, 1, 23, 0,  30};
        tbl[6]  = '{1, 0, 0, 0, 23, 0,  30, 1, 0, 2, 23, 0,  30};
        tbl[7]  = '{0, 0, 1, 0, 23, 0,  30, 1, 0, 2, 23, 59, 30};
        tbl[8]  = '{0, 1, 1, 0, 23, 0,  30, 1, 0, 2, 23, 59, 30};
        tbl[9]  = '{1, 0, 0, 1, 23, 0,  30, 0, 0, 0, 23, 59, 30};
        tbl[10] = '{1, 0, 0, 0, 7,  4,  1,  1, 0, 1, 7,  4,  1};
        tbl[11] = '{1, 1, 0, 0, 7,  4,  1,  1, 0, 2, 7,  4,  1};
        tbl[12] = '{0, 1, 0, 0, 7,  4,  1,  1, 0, 2, 7,  5,  1};
        tbl[13] = '{1, 0, 0, 0, 7,  4,  1,  1, 0, 3, 7,  5,  1};
        tbl[14] = '{0, 0, 1, 0, 7,  4,  1,  1, 0, 3, 7,  5,  0};
        tbl[15] = '{0, 1, 1, 0, 7,  4,  1,  1, 0, 3, 7,  5,  0};
        tbl[16] = '{1, 0, 0, 0, 7,  4,  1,  1, 1, 0, 7,  5,  0};
        tbl[17] = '{0, 0, 0, 0, 7,  4,  1,  0, 0, 0, 7,  5,  0};
        tbl[18] = '{0, 1, 0, 0, 7,  4,  1,  0, 0, 0, 7,  5,  0};
        tbl[19] = '{0, 0, 0, 1, 7,  4,  1,  0, 0, 0, 7,  5,  0};

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 0, 0, 0, 12, 34, 56, "reset0");
        applyStimulus(0, 0, 0, 0, 0, 0, 12, 34, 56, "reset1");

        $display("[TB] directed table");
        for (int i = 0; i < 20; i++) begin
            string nm;
            v = tbl[i];
            nm = $sformatf("vec%0d", i);
            applyStimulus(1, v.mode, v.inc, v.dec, v.cancel, 0, v.ch, v.cm, v.cs, nm);
            cmp({nm, ".tPause"}, 32'(pause),      v.ePause);
            cmp({nm, ".tLoad"},  32'(load),       v.eLoad);
            cmp({nm, ".tField"}, 32'(editField),  v.eField);
            cmp({nm, ".tHour"},  32'(loadHour),   v.eH);
            cmp({nm, ".tMin"},   32'(loadMinute), v.eM);
            cmp({nm, ".tSec"},   32'(loadSecond), v.eS);
        end

        $display("[TB] timeout abort");
        applyStimulus(1, 1, 0, 0, 0, 0, 10, 20, 30, "to_enter");
        cmp("to_enter.blink", 32'(blink), 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 20, 30, "to_t1");
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 20, 30, "to_t2");
        cmp("to_t2.field", 32'(editField), 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 20, 30, "to_t3");
        cmp("to_t3.field", 32'(editField), 0);
        cmp("to_t3.pause", 32'(pause), 0);
        cmp("to_t3.load",  32'(load), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 10, 20, 30, "to_after");
        cmp("to_after.load", 32'(load), 0);

        $display("[TB] timeout rescued by button");
        applyStimulus(1, 1, 0, 0, 0, 0, 10, 20, 30, "tr_enter");
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 20, 30, "tr_t1");
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 20, 30, "tr_t2");
        applyStimulus(1, 0, 1, 0, 0, 1, 10, 20, 30, "tr_t3inc");
        cmp("tr_t3inc.field", 32'(editField), 1);
        cmp("tr_t3inc.hour",  32'(loadHour), 11);
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 20, 30, "tr_t4");
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 20, 30, "tr_t5");
        cmp("tr_t5.field", 32'(editField), 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 10, 20, 30, "tr_t6");
        cmp("tr_t6.field", 32'(editField), 0);

        $display("[TB] reset mid-edit");
        applyStimulus(1, 1, 0, 0, 0, 0, 4, 5, 6, "rm_enter");
        applyStimulus(1, 1, 0, 0, 0, 0, 4, 5, 6, "rm_min");
        applyStimulus(0, 1, 0, 0, 0, 0, 4, 5, 6, "rm_reset");
        cmp("rm_reset.load", 32'(load), 0);
        cmp("rm_reset.hour", 32'(loadHour), 0);

        $display("[TB] random stimulus");
        for (int i = 0; i < 800; i++) begin
            bit rn, md, ic, dc, cn, tk;
            rn = ($urandom_range(0, 99) != 0);
            md = ($urandom_range(0, 5) == 0);
            ic = ($urandom_range(0, 3) == 0);
            dc = ($urandom_range(0, 3) == 0);
            cn = ($urandom_range(0, 24) == 0);
            tk = ($urandom_range(0, 2) == 0);
            applyStimulus(rn, md, ic, dc, cn, tk,
                          $urandom_range(0, HMAX), $urandom_range(0, MSMAX),
                          $urandom_range(0, MSMAX), $sformatf("rnd%0d", i));
        end

        btnMode = 1'b0; btnInc = 1'b0; btnDec = 1'b0; btnCancel = 1'b0; secTick = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
